pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
- Consumer end of the next-PC path: owns the program counter register, drives the PC+4 value into the next-PC selector, and samples the selected next PC when the current instruction retires.
- Fetches each instruction from instruction memory over a req/ack handshake.
- Presents the instruction to decode with a valid flag, honours a pipeline stall, and traps misaligned next-PC values.

Parameters:
- XLEN, 32, address and instruction data width
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-high reset
- pc_next  input  XLEN  selected next PC from the branch/PC+4 selector
- stall  input  1  hold current instruction; blocks retire
- imem_req  output  1  fetch request to instruction memory
- imem_addr  output  XLEN  fetch address, equals pc
- imem_ack  input  1  memory has imem_rdata valid this cycle
- imem_rdata  input  XLEN  fetched instruction word
- pc  output  XLEN  current program counter
- pc_plus4  output  XLEN  pc + 4, to the selector's sequential input
- instr_valid  output  1  instr holds a fetched, unretired instruction
- instr  output  XLEN  fetched instruction word
- misalign_err  output  1  sticky error: pc_next was not word-aligned

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values: pc = RESET_VECTOR, state = FETCH, instr = 0, instr_valid = 0, misalign_err = 0.
- imem_req is combinational, equal to (state == FETCH), so it is 1 in the first cycle after reset deasserts.
- States: FETCH, HOLD, ERROR.
- FETCH:
  - imem_req = 1; imem_addr = pc, held stable until ack.
  - On imem_ack: instr <= imem_rdata; instr_valid <= 1; state <= HOLD.
  - Ack may arrive in the same cycle as the request (zero wait states) or any number of cycles later.
  - stall is ignored in FETCH.
- HOLD:
  - imem_req = 0; instr_valid = 1; instr and pc are stable.
  - stall = 1: all state held, for any number of cycles.
  - stall = 0: retire.
    - pc <= pc_next; instr_valid <= 0.
    - If pc_next[1:0] == 0: state <= FETCH.
    - Otherwise: state <= ERROR and misalign_err <= 1.
- ERROR:
  - imem_req = 0; instr_valid = 0; pc holds the offending pc_next value.
  - Only reset exits this state.
- imem_ack while imem_req = 0 is ignored, with no state change.
- pc_plus4 = pc + 4 in every state, combinational, modulo 2^XLEN: 32'hFFFF_FFFC yields 32'h0000_0000, and no error is raised for the wrap.
- pc_next is sampled only on the retire edge; its value at any other time has no effect.
- Throughput: one instruction per 2 cycles at best (FETCH with immediate ack, then HOLD with stall = 0).
- Reset mid-operation: an outstanding request is abandoned immediately and imem_req drops asynchronously. Instruction memory must tolerate a request withdrawn before ack.

Decomposition:
- Shared package riscv_pkg holds:
  - XLEN
  - INSTR_BYTES = 4
  - the fetch state enum {FETCH, HOLD, ERROR}
  - default RESET_VECTOR
- One sub-module is natural: pc_reg, an XLEN-bit register with async reset to RESET_VECTOR and a load enable, instantiated for pc.
- The state machine and the PC+4 adder stay in pc_fetch_unit.

Test Plan:
- Reset release, ack in same cycle as req, rdata = 32'h0000_0013, pc_next = 32'h4:
  - Cycle 1: imem_req = 1, imem_addr = 0.
  - Cycle 2: instr_valid = 1, instr = 32'h13.
  - Cycle 3: pc = 4, imem_req = 1.
- Ack delayed 3 cycles:
  - imem_addr stays stable and instr_valid = 0 throughout the wait.
  - instr_valid = 1 in the cycle after ack.
- stall held 5 cycles in HOLD with pc_next toggling:
  - pc, instr and instr_valid are unchanged.
  - On stall release, pc loads the pc_next value present at the release edge.
- Branch taken, pc_next = 32'h0000_0100: after retire, imem_addr = 32'h100 and pc_plus4 = 32'h104.
- pc_next = 32'h0000_0102 at retire:
  - misalign_err = 1, pc = 32'h102, imem_req = 0.
  - Stays in ERROR despite later acks; reset clears it.
- Reset asserted mid-FETCH, plus wrap check:
  - Reset while waiting for ack: imem_req drops the same cycle; after release, imem_addr = RESET_VECTOR.
  - Separately, force pc = 32'hFFFF_FFFC: pc_plus4 = 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared constants and types for the instruction fetch front end.
package riscv_pkg;

   localparam int XLEN        = 32;
   localparam int INSTR_BYTES = 4;

   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      ERROR = 2'd2
   } fetch_state_e;

   function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
      return (addr_lsb == 2'b00);
   endfunction

endpackage

// File: rtl/pc_fetch_unit_pc_reg.sv
// Program counter register: async reset to the reset vector, loads on enable.
module pc_reg #(
   parameter int               XLEN         = 32,
   parameter logic [XLEN-1:0]  RESET_VECTOR = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_en,
   input  logic [XLEN-1:0]  d,
   output logic [XLEN-1:0]  q
);

   logic [XLEN-1:0] value_q;
   logic [XLEN-1:0] value_d;

   always_comb begin
      value_d = value_q;
      if (load_en) begin
         value_d = d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         value_q <= RESET_VECTOR;
      end else begin
         value_q <= value_d;
      end
   end

   assign q = value_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the PC, fetches over req/ack, hands instructions to decode.
//
// state | meaning
// FETCH | request outstanding at imem_addr = pc, waiting for imem_ack
// HOLD  | instruction valid to decode, waiting for stall to drop to retire
// ERROR | retired into a misaligned pc_next; parked until reset
module pc_fetch_unit #(
   parameter int               XLEN         = riscv_pkg::XLEN,
   parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(riscv_pkg::DEFAULT_RESET_VECTOR)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [XLEN-1:0]  pc_next,
   input  logic             stall,
   output logic             imem_req,
   output logic [XLEN-1:0]  imem_addr,
   input  logic             imem_ack,
   input  logic [XLEN-1:0]  imem_rdata,
   output logic [XLEN-1:0]  pc,
   output logic [XLEN-1:0]  pc_plus4,
   output logic             instr_valid,
   output logic [XLEN-1:0]  instr,
   output logic             misalign_err
);

   import riscv_pkg::*;

   localparam logic [XLEN-1:0] PC_STEP = XLEN'(INSTR_BYTES);

   fetch_state_e     state_q, state_d;
   logic [XLEN-1:0]  instr_q, instr_d;
   logic             instr_valid_q, instr_valid_d;
   logic             misalign_err_q, misalign_err_d;
   logic             pc_load;
   logic [XLEN-1:0]  pc_q;

   pc_reg #(
      .XLEN         (XLEN),
      .RESET_VECTOR (RESET_VECTOR)
   ) u_pc_reg (
      .clk     (clk),
      .reset   (reset),
      .load_en (pc_load),
      .d       (pc_next),
      .q       (pc_q)
   );

   always_comb begin
      state_d        = state_q;
      instr_d        = instr_q;
      instr_valid_d  = instr_valid_q;
      misalign_err_d = misalign_err_q;
      pc_load        = 1'b0;

      unique case (state_q)
         FETCH: begin
            if (imem_ack) begin
               instr_d       = imem_rdata;
               instr_valid_d = 1'b1;
               state_d       = HOLD;
            end
         end
         HOLD: begin
            // Retire: pc_next is only sampled here, never in FETCH or ERROR.
            if (!stall) begin
               pc_load       = 1'b1;
               instr_valid_d = 1'b0;
               if (is_word_aligned(pc_next[1:0])) begin
                  state_d = FETCH;
               end else begin
                  state_d        = ERROR;
                  misalign_err_d = 1'b1;
               end
            end
         end
         ERROR: begin
            state_d = ERROR;
         end
         default: begin
            state_d = FETCH;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= FETCH;
         instr_q        <= '0;
         instr_valid_q  <= 1'b0;
         misalign_err_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         instr_q        <= instr_d;
         instr_valid_q  <= instr_valid_d;
         misalign_err_q <= misalign_err_d;
      end
   end

   // Gated by reset so an outstanding request is withdrawn the moment reset rises.
   assign imem_req     = (state_q == FETCH) && !reset;
   assign imem_addr    = pc_q;
   assign pc           = pc_q;
   assign pc_plus4     = pc_q + PC_STEP;
   assign instr        = instr_q;
   assign instr_valid  = instr_valid_q;
   assign misalign_err = misalign_err_q;

endmodule
